// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between write-side producers, the round-robin arbiter and the FIFO write port.
// The master modport is the arbiter; the slave modport is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
);
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
  logic                          i_wfull;
  logic [NUM_REQ-1:0]            o_gnt;
  logic [NUM_REQ-1:0]            o_ack;
  logic [DATA_WIDTH-1:0]         o_wdata;
  logic                          o_winc;
  logic                          o_busy;
  logic [CW-1:0]                 o_beat_cnt;

  modport master (
    input  i_req, i_data, i_wfull,
    output o_gnt, o_ack, o_wdata, o_winc, o_busy, o_beat_cnt
  );

  modport slave (
    output i_req, i_data, i_wfull,
    input  o_gnt, o_ack, o_wdata, o_winc, o_busy, o_beat_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ producers.
// A grant lasts until MAX_BURST beats are accepted or the owner drops its request.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic          i_wclk,
  input  logic          i_wrst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] BURST_LEN = CW'(MAX_BURST);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;

  logic                  own_req_s;
  logic                  acc_s;
  logic                  release_s;
  logic [PW-1:0]         owner_s;
  logic [PW-1:0]         next_ptr_s;
  logic [PW-1:0]         arb_ptr_s;
  logic [NUM_REQ-1:0]    pick_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  // First requester at or after ptr, scanning cyclically.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [PW-1:0]      ptr);
    logic [NUM_REQ-1:0] sel;
    logic               found;
    logic [PW-1:0]      idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return sel;
  endfunction

  // Owner index and write-data mux, both driven from the one-hot grant.
  always_comb begin
    owner_s = '0;
    wdata_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_s = owner_s | (gnt_q[i] ? PW'(i) : '0);
      wdata_s = wdata_s | (bus.i_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_q[i]}});
    end
  end

  // Accept/release decisions and the re-arbitration pointer.
  always_comb begin
    own_req_s  = |(gnt_q & bus.i_req);
    acc_s      = own_req_s & ~bus.i_wfull;
    release_s  = (acc_s && ((cnt_q + CW'(1)) == BURST_LEN)) || !own_req_s;
    next_ptr_s = (owner_s == LAST_IDX) ? '0 : owner_s + PW'(1);
    arb_ptr_s  = (state_q == ST_GRANT) ? next_ptr_s : ptr_q;
    pick_s     = rr_pick(bus.i_req, arb_ptr_s);
  end

  // Next-state logic; a release re-arbitrates in the same cycle so bursts chain without a bubble.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|pick_s) begin
          state_d = ST_GRANT;
          gnt_d   = pick_s;
          cnt_d   = '0;
        end else begin
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          ptr_d   = next_ptr_s;
          cnt_d   = '0;
          gnt_d   = pick_s;
          state_d = (|pick_s) ? ST_GRANT : ST_IDLE;
        end else if (acc_s) begin
          cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        ptr_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_wclk) begin
    if (!i_wrst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.o_gnt      = gnt_q;
  assign bus.o_ack      = gnt_q & bus.i_req & {NUM_REQ{~bus.i_wfull}};
  assign bus.o_winc     = acc_s;
  assign bus.o_wdata    = wdata_s;
  assign bus.o_busy     = (state_q == ST_GRANT);
  assign bus.o_beat_cnt = cnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 requesters, 8-bit data, bursts of 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] seq [NR];

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_wclk   (clk),
    .i_wrst_n (rst_n),
    .bus      (bus.master)
  );

  // Requester k presents {k, sequence number}; the bench advances seq on expected accepts.
  task automatic drive_data();
    for (int k = 0; k < NR; k++) bus.i_data[k*DW +: DW] = {4'(k), seq[k]};
  endtask

  task automatic clear_seq();
    for (int k = 0; k < NR; k++) seq[k] = 4'd0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.i_req   = 4'b1111;
    bus.i_wfull = 1'b0;
    clear_seq();
    drive_data();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++; if (bus.o_gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt c=%0d got=%b exp=0000", c, bus.o_gnt); end
      total++; if (bus.o_winc !== 1'b0) begin bad++; $display("FAIL rst_winc c=%0d got=%b exp=0", c, bus.o_winc); end
      total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy c=%0d got=%b exp=0", c, bus.o_busy); end
      total++; if (bus.o_beat_cnt !== 3'd0) begin bad++; $display("FAIL rst_cnt c=%0d got=%0d exp=0", c, bus.o_beat_cnt); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.o_gnt !== 4'b0000) begin bad++; $display("FAIL rst_rel_gnt got=%b exp=0000", bus.o_gnt); end
    @(negedge clk); #1;
    total++; if (bus.o_gnt !== 4'b0001) begin bad++; $display("FAIL rst_first_gnt got=%b exp=0001", bus.o_gnt); end
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL rst_first_busy got=%b exp=1", bus.o_busy); end
  endtask

  task automatic test_round_robin();
    int         own;
    logic [3:0] exp_g;
    logic [7:0] exp_w;
    bus.i_req   = 4'b1111;
    bus.i_wfull = 1'b0;
    clear_seq();
    drive_data();
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive_data();
      #1;
      own   = (c / 4) % 4;
      exp_g = 4'b0001 << own;
      exp_w = {4'(own), seq[own]};
      total++; if (bus.o_gnt !== exp_g) begin bad++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.o_gnt, exp_g); end
      total++; if (bus.o_ack !== exp_g) begin bad++; $display("FAIL rr_ack c=%0d got=%b exp=%b", c, bus.o_ack, exp_g); end
      total++; if (bus.o_winc !== 1'b1) begin bad++; $display("FAIL rr_winc c=%0d got=%b exp=1", c, bus.o_winc); end
      total++; if (bus.o_beat_cnt !== CW'(c % 4)) begin bad++; $display("FAIL rr_cnt c=%0d got=%0d exp=%0d", c, bus.o_beat_cnt, c % 4); end
      total++; if (bus.o_wdata !== exp_w) begin bad++; $display("FAIL rr_wdata c=%0d got=%h exp=%h", c, bus.o_wdata, exp_w); end
      seq[own] = seq[own] + 4'd1;
    end
  endtask

  task automatic test_short_burst();
    int wcount = 0;
    bus.i_req   = 4'b0100;
    bus.i_wfull = 1'b0;
    bus.i_data  = '0;
    bus.i_data[2*DW +: DW] = 8'hA1;
    apply_reset();
    @(negedge clk); #1;
    wcount += int'(bus.o_winc);
    total++; if (bus.o_gnt !== 4'b0100) begin bad++; $display("FAIL sb_gnt0 got=%b exp=0100", bus.o_gnt); end
    total++; if (bus.o_beat_cnt !== 3'd0) begin bad++; $display("FAIL sb_cnt0 got=%0d exp=0", bus.o_beat_cnt); end
    total++; if (bus.o_wdata !== 8'hA1) begin bad++; $display("FAIL sb_wdata0 got=%h exp=a1", bus.o_wdata); end
    @(negedge clk);
    bus.i_data[2*DW +: DW] = 8'hA2;
    #1;
    wcount += int'(bus.o_winc);
    total++; if (bus.o_beat_cnt !== 3'd1) begin bad++; $display("FAIL sb_cnt1 got=%0d exp=1", bus.o_beat_cnt); end
    total++; if (bus.o_wdata !== 8'hA2) begin bad++; $display("FAIL sb_wdata1 got=%h exp=a2", bus.o_wdata); end
    @(negedge clk);
    bus.i_req = 4'b0000;
    #1;
    wcount += int'(bus.o_winc);
    total++; if (bus.o_beat_cnt !== 3'd2) begin bad++; $display("FAIL sb_cnt2 got=%0d exp=2", bus.o_beat_cnt); end
    total++; if (bus.o_ack !== 4'b0000) begin bad++; $display("FAIL sb_ack2 got=%b exp=0000", bus.o_ack); end
    @(negedge clk);
    bus.i_req = 4'b0101;
    #1;
    total++; if (bus.o_gnt !== 4'b0000) begin bad++; $display("FAIL sb_idle_gnt got=%b exp=0000", bus.o_gnt); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL sb_idle_busy got=%b exp=0", bus.o_busy); end
    total++; if (bus.o_beat_cnt !== 3'd0) begin bad++; $display("FAIL sb_idle_cnt got=%0d exp=0", bus.o_beat_cnt); end
    total++; if (bus.o_wdata !== 8'h00) begin bad++; $display("FAIL sb_idle_wdata got=%h exp=00", bus.o_wdata); end
    total++; if (bus.o_winc !== 1'b0) begin bad++; $display("FAIL sb_idle_winc got=%b exp=0", bus.o_winc); end
    total++; if (wcount != 2) begin bad++; $display("FAIL sb_wcount got=%0d exp=2", wcount); end
    @(negedge clk); #1;
    total++; if (bus.o_gnt !== 4'b0001) begin bad++; $display("FAIL sb_wrap_gnt got=%b exp=0001", bus.o_gnt); end
  endtask

  task automatic test_backpressure();
    int         bp_cnt  [10] = '{0, 1, 2, 2, 2, 2, 2, 2, 3, 0};
    logic       bp_winc [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_g;
    logic [3:0] exp_a;
    bus.i_req   = 4'b0010;
    bus.i_wfull = 1'b0;
    clear_seq();
    drive_data();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.i_wfull = (c >= 2 && c <= 6);
      if (c == 8) bus.i_req = 4'b0110;
      drive_data();
      #1;
      exp_g = (c < 9) ? 4'b0010 : 4'b0100;
      exp_a = bp_winc[c] ? exp_g : 4'b0000;
      total++; if (bus.o_gnt !== exp_g) begin bad++; $display("FAIL bp_gnt c=%0d got=%b exp=%b", c, bus.o_gnt, exp_g); end
      total++; if (bus.o_winc !== bp_winc[c]) begin bad++; $display("FAIL bp_winc c=%0d got=%b exp=%b", c, bus.o_winc, bp_winc[c]); end
      total++; if (bus.o_ack !== exp_a) begin bad++; $display("FAIL bp_ack c=%0d got=%b exp=%b", c, bus.o_ack, exp_a); end
      total++; if (bus.o_beat_cnt !== CW'(bp_cnt[c])) begin bad++; $display("FAIL bp_cnt c=%0d got=%0d exp=%0d", c, bus.o_beat_cnt, bp_cnt[c]); end
    end
    bus.i_wfull = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] mr_gnt [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000,
                                4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b1000};
    int         mr_cnt [10] = '{0, 1, 2, 3, 0, 1, 2, 0, 0, 0};
    bus.i_req   = 4'b0010;
    bus.i_wfull = 1'b0;
    clear_seq();
    drive_data();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) bus.i_req = 4'b1010;
      if (c == 4) bus.i_req = 4'b1000;
      #1;
      total++; if (bus.o_gnt !== mr_gnt[c]) begin bad++; $display("FAIL mr_gnt c=%0d got=%b exp=%b", c, bus.o_gnt, mr_gnt[c]); end
      total++; if (bus.o_beat_cnt !== CW'(mr_cnt[c])) begin bad++; $display("FAIL mr_cnt c=%0d got=%0d exp=%0d", c, bus.o_beat_cnt, mr_cnt[c]); end
      if (c == 7) begin
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%b exp=0", bus.o_busy); end
        total++; if (bus.o_winc !== 1'b0) begin bad++; $display("FAIL mr_winc got=%b exp=0", bus.o_winc); end
      end
      if (c == 6) rst_n = 1'b0;
      if (c == 7) begin
        rst_n     = 1'b1;
        bus.i_req = 4'b1001;
      end
      if (c == 8) bus.i_req = 4'b1000;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_short_burst();
    test_backpressure();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
